bcd_round_serial: RTL and testbench

//  Parametrised BCD rounder for the frequency-counter display path. Drops 0..MAX_DROP low digits

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_digit_inc.sv | 24 ++
 rtl/bcd_round_serial.sv | 181 ++++++++++++++++++
 tb/tb_bcd_round_serial.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD rounder.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_TEN  = 4'd10;

    // Rounding mode codes as presented on the mode port.
    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_CEIL      = 2'd3
    } rnd_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_PROP   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_digit_inc.sv
// Combinational single-digit BCD increment.
//   digit       : BCD digit to increment
//   sum_c       : digit + 1, wrapped to 0 on a decimal carry
//   carry_out_c : digit was 9
//   invalid_c   : digit is not a legal BCD code (>9)
module bcd_digit_inc
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] sum_c,
    output logic               carry_out_c,
    output logic               invalid_c
);

    logic [DIGIT_W:0] raw_c;

    always_comb begin
        raw_c       = {1'b0, digit} + (DIGIT_W+1)'(1);
        invalid_c   = (digit > BCD_NINE);
        carry_out_c = (raw_c == {1'b0, BCD_TEN});
        sum_c       = carry_out_c ? '0 : raw_c[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_round_serial.sv
// Serial BCD rounder: drops 0..MAX_DROP low digits under a selectable rounding
// mode, rippling the increment one digit per clock.
//   clk, rst_n   : clock, async active-low reset
//   in_valid/in_ready, bcd_in, drop_digits, mode : request side
//   out_valid/out_ready, bcd_out, overflow, err  : result side
module bcd_round_serial
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned MAX_DROP   = 3,
    parameter bit          SATURATE   = 1'b0,
    localparam int unsigned DW        = $clog2(MAX_DROP + 1),
    localparam int unsigned BW        = DIGIT_W * NUM_DIGITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] bcd_in,
    input  logic [DW-1:0] drop_digits,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] bcd_out,
    output logic          overflow,
    output logic          err
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);

    state_e               state_q, state_d;
    logic [BW-1:0]        w_q, w_d;
    logic [DW-1:0]        d_q, d_d;
    rnd_mode_e            mode_q, mode_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;

    logic                 err_c, inc_c, sticky_c, last_c;
    logic [DIGIT_W-1:0]   rdig_c, lsb_c, cur_digit_c, sum_c;
    logic                 carry_c, invalid_c;
    logic [BW-1:0]        shifted_c;
    logic [DW-1:0]        d_clamp_c;

    // Round digit, sticky and kept-LSB extraction from the captured word.
    always_comb begin
        err_c    = 1'b0;
        sticky_c = 1'b0;
        rdig_c   = '0;
        lsb_c    = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (w_q[DIGIT_W*i +: DIGIT_W] > BCD_NINE) err_c = 1'b1;
            if (i + 1 < int'(d_q)) sticky_c = sticky_c | (w_q[DIGIT_W*i +: DIGIT_W] != '0);
            if (i + 1 == int'(d_q)) rdig_c = w_q[DIGIT_W*i +: DIGIT_W];
            if (i == int'(d_q)) lsb_c = w_q[DIGIT_W*i +: DIGIT_W];
        end
        unique case (mode_q)
            RND_TRUNC:     inc_c = 1'b0;
            RND_HALF_UP:   inc_c = (rdig_c >= 4'd5);
            RND_HALF_EVEN: inc_c = (rdig_c > 4'd5) || ((rdig_c == 4'd5) && (sticky_c || lsb_c[0]));
            RND_CEIL:      inc_c = (rdig_c != '0) || sticky_c;
            default:       inc_c = 1'b0;
        endcase
        if (d_q == '0) inc_c = 1'b0;
        shifted_c = w_q >> (DIGIT_W * int'(d_q));
        last_c    = (int'(idx_q) + int'(d_q) == int'(NUM_DIGITS) - 1);
        d_clamp_c = (drop_digits > DW'(MAX_DROP)) ? DW'(MAX_DROP) : drop_digits;
    end

    assign cur_digit_c = w_q[DIGIT_W*idx_q +: DIGIT_W];

    bcd_digit_inc u_inc (
        .digit       (cur_digit_c),
        .sum_c       (sum_c),
        .carry_out_c (carry_c),
        .invalid_c   (invalid_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (in_valid) state_d = ST_DECIDE;
            ST_DECIDE: state_d = (err_c || !inc_c) ? ST_DONE : ST_PROP;
            ST_PROP:   if (!carry_c || last_c) state_d = ST_DONE;
            ST_DONE:   if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        w_d         = w_q;
        d_d         = d_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_d    = bcd_in;
                    d_d    = d_clamp_c;
                    mode_d = rnd_mode_e'(mode);
                    idx_d  = '0;
                    ovf_d  = 1'b0;
                    err_d  = 1'b0;
                end
            end
            ST_DECIDE: begin
                idx_d = '0;
                if (err_c) begin
                    err_d = 1'b1;
                    w_d   = '0;
                end else begin
                    w_d = shifted_c;
                end
            end
            ST_PROP: begin
                // Digits were validated in DECIDE; folded in only as a guard.
                err_d = err_q | invalid_c;
                if (carry_c) begin
                    w_d[DIGIT_W*idx_q +: DIGIT_W] = '0;
                    if (last_c) begin
                        ovf_d = 1'b1;
                        if (SATURATE) begin
                            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                                if (i + int'(d_q) < int'(NUM_DIGITS)) w_d[DIGIT_W*i +: DIGIT_W] = BCD_NINE;
                            end
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    w_d[DIGIT_W*idx_q +: DIGIT_W] = sum_c;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q         <= '0;
            d_q         <= '0;
            mode_q      <= RND_TRUNC;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            w_q         <= w_d;
            d_q         <= d_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd_out   = w_q;
    assign overflow  = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_round_serial.sv
// Scoreboard bench for bcd_round_serial: wrap (u_dut) and saturate (u_sat)
// instances share stimulus; expected results are queued at issue time and
// checked by monitors when each instance presents a result.
module tb_bcd_round_serial;

    localparam int unsigned ND = 6;
    localparam int unsigned MD = 3;
    localparam int unsigned DW = 2;
    localparam int unsigned BW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [BW-1:0] bcd_in;
    logic [DW-1:0] drop_digits;
    logic [1:0]    mode;
    logic          out_ready;

    logic          in_ready, out_valid, overflow, err;
    logic [BW-1:0] bcd_out;
    logic          in_ready_s, out_valid_s, overflow_s, err_s;
    logic [BW-1:0] bcd_out_s;

    typedef struct {
        logic [BW-1:0] bcd;
        logic          ovf;
        logic          err;
        int            lat;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_s_q[$];
    int   acc_q[$];
    exp_t cur, cur_s;
    logic seen   = 1'b0;
    logic seen_s = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;

    bcd_round_serial #(.NUM_DIGITS(ND), .MAX_DROP(MD), .SATURATE(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bcd_in(bcd_in), .drop_digits(drop_digits), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out),
        .overflow(overflow), .err(err)
    );

    bcd_round_serial #(.NUM_DIGITS(ND), .MAX_DROP(MD), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .bcd_in(bcd_in), .drop_digits(drop_digits), .mode(mode),
        .out_valid(out_valid_s), .out_ready(out_ready), .bcd_out(bcd_out_s),
        .overflow(overflow_s), .err(err_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor for the wrapping instance: latency, flags, held data, in_ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got %0h expected none", bcd_out);
                        cur.bcd = bcd_out; cur.ovf = overflow; cur.err = err; cur.name = "unexpected";
                    end else begin
                        cur = exp_q.pop_front();
                        chk({cur.name, " latency"}, 32'(cyc - acc_q.pop_front()), 32'(cur.lat));
                        chk({cur.name, " overflow"}, 32'(overflow), 32'(cur.ovf));
                        chk({cur.name, " err"}, 32'(err), 32'(cur.err));
                    end
                end
                chk({cur.name, " bcd_out"}, 32'(bcd_out), 32'(cur.bcd));
                chk({cur.name, " in_ready_busy"}, 32'(in_ready), 32'd0);
                if (out_ready) seen = 1'b0;
            end
        end
    end

    // Monitor for the saturating instance.
    always @(negedge clk) begin
        if (rst_n && out_valid_s) begin
            if (!seen_s) begin
                seen_s = 1'b1;
                if (exp_s_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_sat_result: got %0h expected none", bcd_out_s);
                end else begin
                    cur_s = exp_s_q.pop_front();
                    chk({cur_s.name, " sat bcd_out"}, 32'(bcd_out_s), 32'(cur_s.bcd));
                    chk({cur_s.name, " sat overflow"}, 32'(overflow_s), 32'(cur_s.ovf));
                    chk({cur_s.name, " sat err"}, 32'(err_s), 32'(cur_s.err));
                end
            end
            if (out_ready) seen_s = 1'b0;
        end
    end

    task automatic send(input logic [BW-1:0] b, input int d, input int m,
                        input logic [BW-1:0] e, input logic eo, input logic ee,
                        input logic [BW-1:0] es, input logic eos,
                        input int lat, input string nm, input bit push);
        exp_t x;
        int   n;
        if (push) begin
            x.bcd = e;  x.ovf = eo;  x.err = ee; x.lat = lat; x.name = nm;
            exp_q.push_back(x);
            x.bcd = es; x.ovf = eos;
            exp_s_q.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        bcd_in      = b;
        drop_digits = DW'(d);
        mode        = 2'(m);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL %s accept_timeout: got in_ready 0 expected 1", nm);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        bcd_in      = 24'hFFFFFF;
        mode        = 2'd0;
        drop_digits = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp_s_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " in_ready"},  32'(in_ready),  32'd1);
        chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " bcd_out"},   32'(bcd_out),   32'd0);
        chk({nm, " overflow"},  32'(overflow),  32'd0);
        chk({nm, " err"},       32'(err),       32'd0);
        chk({nm, " sat bcd_out"}, 32'(bcd_out_s), 32'd0);
        chk({nm, " sat in_ready"}, 32'(in_ready_s), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        bcd_in      = '0;
        drop_digits = '0;
        mode        = 2'd0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //    bcd_in    d  m  exp       ovf err sat_exp   sovf lat name
        send(24'h123456, 1, 1, 24'h012346, 0, 0, 24'h012346, 0, 3, "half_up_basic", 1);
        send(24'h123454, 1, 1, 24'h012345, 0, 0, 24'h012345, 0, 2, "half_up_below", 1);
        send(24'h000025, 1, 2, 24'h000002, 0, 0, 24'h000002, 0, 2, "half_even_tie_even", 1);
        send(24'h000035, 1, 2, 24'h000004, 0, 0, 24'h000004, 0, 3, "half_even_tie_odd", 1);
        send(24'h000251, 2, 2, 24'h000003, 0, 0, 24'h000003, 0, 3, "half_even_sticky", 1);
        send(24'h999995, 1, 1, 24'h000000, 1, 0, 24'h099999, 1, 7, "overflow", 1);
        send(24'h001950, 2, 1, 24'h000020, 0, 0, 24'h000020, 0, 4, "carry_ripple", 1);
        send(24'h123001, 3, 3, 24'h000124, 0, 0, 24'h000124, 0, 3, "ceil_sticky", 1);
        send(24'h123001, 3, 0, 24'h000123, 0, 0, 24'h000123, 0, 2, "trunc_d3", 1);
        send(24'h123000, 3, 3, 24'h000123, 0, 0, 24'h000123, 0, 2, "ceil_exact", 1);
        send(24'h12A456, 1, 1, 24'h000000, 0, 1, 24'h000000, 0, 2, "bad_digit", 1);
        send(24'h987654, 0, 3, 24'h987654, 0, 0, 24'h987654, 0, 2, "drop_zero", 1);
        drain();

        // Downstream stall: result must stay put while out_ready is low.
        out_ready = 1'b0;
        send(24'h543219, 1, 0, 24'h054321, 0, 0, 24'h054321, 0, 2, "stall", 1);
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset while the carry is rippling through the kept digits.
        send(24'h999995, 1, 1, 24'h0, 0, 0, 24'h0, 0, 0, "killed", 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("mid_prop_reset");
        acc_q.delete();
        seen   = 1'b0;
        seen_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(24'h123456, 1, 1, 24'h012346, 0, 0, 24'h012346, 0, 3, "after_reset", 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
